gpu_regfile: RTL and testbench

Per-lane register file for the GPU core: a parametrised general-purpose register array and predicate array with two registered read ports, one write port, and a predicate read/write port. Also provides a context save/restore engine that streams a window of registers, plus the predicates, out to and back from the work-queue logic over valid/ready channels. Used by the scheduler when a task is swapped on or off a core.

---
 rtl/gpu_pkg.sv | 33 +++
 rtl/gpu_regfile_if.sv | 65 ++++++
 rtl/gpu_regfile_ctx_fsm.sv | 116 +++++++++++
 rtl/gpu_regfile.sv | 137 +++++++++++++
 tb/tb_gpu_regfile.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pkg
// Purpose  : Shared definitions for the GPU per-lane register file:
//            - default sizes (data width, register count, predicate count)
//            - context save/restore state encoding
//            - predicate-beat packing helper used by the save stream
// Revision : 1.0  initial release
// ============================================================================
package gpu_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_NUM_PREDS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } ctx_state_t;

    // The predicate beat carries the predicates in the low bits, upper bits 0.
    function automatic logic [DEF_DATA_W-1:0] pack_pred_beat(
        input logic [DEF_NUM_PREDS-1:0] preds
    );
        logic [DEF_DATA_W-1:0] beat;
        beat = '0;
        beat[DEF_NUM_PREDS-1:0] = preds;
        return beat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu_regfile_if
// Purpose  : Bus bundle for the GPU register file.
//            Ports grouped: read ports (rd_addr*/rd_data*), write port
//            (wr_*), predicate port (pred_*), context control
//            (save_start/restore_start/busy/done), context out stream
//            (ctx_out_*) and context in stream (ctx_in_*).
//            master = scheduler/work-queue side, slave = register file.
// Revision : 1.0  initial release
// ============================================================================
interface gpu_regfile_if
    import gpu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_PREDS = DEF_NUM_PREDS,
    parameter int CTX_REGS  = 8
);
    localparam int c_addr_w = $clog2(NUM_REGS);
    localparam int c_pred_w = (NUM_PREDS > 1) ? $clog2(NUM_PREDS) : 1;
    localparam int c_idx_w  = $clog2(CTX_REGS + 1);

    logic [c_addr_w-1:0] rd_addr0;
    logic [c_addr_w-1:0] rd_addr1;
    logic [DATA_W-1:0]   rd_data0;
    logic [DATA_W-1:0]   rd_data1;
    logic                wr_en;
    logic [c_addr_w-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [c_pred_w-1:0] pred_rd_addr;
    logic                pred_rd_data;
    logic                pred_wr_en;
    logic [c_pred_w-1:0] pred_wr_addr;
    logic                pred_wr_data;
    logic                save_start;
    logic                restore_start;
    logic                busy;
    logic                done;
    logic                ctx_out_valid;
    logic                ctx_out_ready;
    logic [DATA_W-1:0]   ctx_out_data;
    logic [c_idx_w-1:0]  ctx_out_idx;
    logic                ctx_in_valid;
    logic                ctx_in_ready;
    logic [DATA_W-1:0]   ctx_in_data;

    modport master (
        output rd_addr0, rd_addr1, wr_en, wr_addr, wr_data,
        output pred_rd_addr, pred_wr_en, pred_wr_addr, pred_wr_data,
        output save_start, restore_start, ctx_out_ready, ctx_in_valid, ctx_in_data,
        input  rd_data0, rd_data1, pred_rd_data, busy, done,
        input  ctx_out_valid, ctx_out_data, ctx_out_idx, ctx_in_ready
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_en, wr_addr, wr_data,
        input  pred_rd_addr, pred_wr_en, pred_wr_addr, pred_wr_data,
        input  save_start, restore_start, ctx_out_ready, ctx_in_valid, ctx_in_data,
        output rd_data0, rd_data1, pred_rd_data, busy, done,
        output ctx_out_valid, ctx_out_data, ctx_out_idx, ctx_in_ready
    );

endinterface
`default_nettype wire

// File: rtl/gpu_regfile_ctx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : gpu_regfile_ctx_fsm
// Purpose  : Context save/restore sequencer. Tracks state and beat counter
//            (0..CTX_REGS) and generates the stream handshakes.
// Ports    : clk, rst            clock, async active-high reset
//            i_save_start        request save (wins over restore)
//            i_restore_start     request restore
//            i_out_ready         save stream ready from consumer
//            i_in_valid          restore stream valid from producer
//            o_busy, o_done      status / completion pulse
//            o_out_valid         save stream valid
//            o_in_ready          restore stream ready
//            o_beat              current beat index
//            o_restore_we        restore beat accepted this cycle
// Revision : 1.0  initial release
// ============================================================================
module gpu_regfile_ctx_fsm
    import gpu_pkg::*;
#(
    parameter int CTX_REGS = 8,
    parameter int IDX_W    = $clog2(CTX_REGS + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_save_start,
    input  wire logic             i_restore_start,
    input  wire logic             i_out_ready,
    input  wire logic             i_in_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_out_valid,
    output logic                  o_in_ready,
    output logic [IDX_W-1:0]      o_beat,
    output logic                  o_restore_we
);

    localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(CTX_REGS);

    ctx_state_t       r_state;
    logic [IDX_W-1:0] r_beat;
    logic             r_busy;
    logic             r_done;
    logic             r_out_valid;
    logic             r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (i_save_start) begin
                        r_state     <= SAVE;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (i_restore_start) begin
                        r_state    <= RESTORE;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                SAVE: begin
                    if (i_out_ready) begin
                        if (r_beat == c_last_beat) begin
                            r_state     <= IDLE;
                            r_beat      <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_beat <= r_beat + IDX_W'(1);
                        end
                    end
                end
                RESTORE: begin
                    if (i_in_valid) begin
                        if (r_beat == c_last_beat) begin
                            r_state    <= IDLE;
                            r_beat     <= '0;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_beat <= r_beat + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_beat      <= '0;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_out_valid  = r_out_valid;
    assign o_in_ready   = r_in_ready;
    assign o_beat       = r_beat;
    // The beat is committed on the same edge that accepts it.
    assign o_restore_we = r_in_ready & i_in_valid;

endmodule
`default_nettype wire

// File: rtl/gpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : gpu_regfile
// Purpose  : Per-lane GPU register file with predicate array and a context
//            save/restore engine.
// Ports    : clk   clock
//            rst   async active-high reset
//            bus   gpu_regfile_if.slave: two registered read ports with
//                  write bypass, one write port, predicate read/write port,
//                  save/restore control and the ctx_out/ctx_in streams.
// Revision : 1.0  initial release
// ============================================================================
module gpu_regfile
    import gpu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_PREDS = DEF_NUM_PREDS,
    parameter int CTX_BASE  = 0,
    parameter int CTX_REGS  = 8,
    parameter int ZERO_REG  = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    gpu_regfile_if.slave  bus
);

    localparam int c_addr_w = $clog2(NUM_REGS);
    localparam int c_idx_w  = $clog2(CTX_REGS + 1);
    localparam bit c_zero   = (ZERO_REG != 0);
    localparam logic [c_addr_w-1:0] c_ctx_base  = c_addr_w'(CTX_BASE);
    localparam logic [c_idx_w-1:0]  c_pred_beat = c_idx_w'(CTX_REGS);

    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic [NUM_PREDS-1:0] r_preds;
    logic [DATA_W-1:0]    r_rd_data0;
    logic [DATA_W-1:0]    r_rd_data1;
    logic                 r_pred_rd_data;

    logic                 w_busy;
    logic                 w_out_valid;
    logic [c_idx_w-1:0]   w_beat;
    logic                 w_rs_we;
    logic                 w_wr_acc;
    logic                 w_pwr_acc;
    logic [c_addr_w-1:0]  w_beat_addr;
    logic                 w_beat_is_pred;
    logic                 w_rs_reg_we;
    logic                 w_rs_pred_we;
    logic [DATA_W-1:0]    w_sv_reg;
    logic [DATA_W-1:0]    w_sv_pred;
    logic [DATA_W-1:0]    w_rd0;
    logic [DATA_W-1:0]    w_rd1;
    logic                 w_prd;

    gpu_regfile_ctx_fsm #(
        .CTX_REGS (CTX_REGS),
        .IDX_W    (c_idx_w)
    ) u_ctx_fsm (
        .clk             (clk),
        .rst             (rst),
        .i_save_start    (bus.save_start),
        .i_restore_start (bus.restore_start),
        .i_out_ready     (bus.ctx_out_ready),
        .i_in_valid      (bus.ctx_in_valid),
        .o_busy          (w_busy),
        .o_done          (bus.done),
        .o_out_valid     (w_out_valid),
        .o_in_ready      (bus.ctx_in_ready),
        .o_beat          (w_beat),
        .o_restore_we    (w_rs_we)
    );

    // Port writes are ignored while a context transfer owns the array;
    // writes to r0 are dropped up front so they also never bypass.
    assign w_wr_acc  = bus.wr_en && !w_busy && !(c_zero && (bus.wr_addr == '0));
    assign w_pwr_acc = bus.pred_wr_en && !w_busy;

    assign w_beat_addr    = c_ctx_base + c_addr_w'(w_beat);
    assign w_beat_is_pred = (w_beat == c_pred_beat);
    assign w_rs_reg_we    = w_rs_we && !w_beat_is_pred && !(c_zero && (w_beat_addr == '0));
    assign w_rs_pred_we   = w_rs_we && w_beat_is_pred;

    assign w_sv_reg = (c_zero && (w_beat_addr == '0)) ? '0 : r_regs[w_beat_addr];

    generate
        if (DATA_W == DEF_DATA_W && NUM_PREDS == DEF_NUM_PREDS) begin : g_pred_helper
            assign w_sv_pred = pack_pred_beat(r_preds);
        end else begin : g_pred_ext
            always_comb begin
                w_sv_pred = '0;
                w_sv_pred[NUM_PREDS-1:0] = r_preds;
            end
        end
    endgenerate

    // Read muxes: zero register beats bypass, bypass beats array contents.
    always_comb begin
        w_rd0 = r_regs[bus.rd_addr0];
        if (w_wr_acc && (bus.wr_addr == bus.rd_addr0)) w_rd0 = bus.wr_data;
        if (c_zero && (bus.rd_addr0 == '0))            w_rd0 = '0;
        w_rd1 = r_regs[bus.rd_addr1];
        if (w_wr_acc && (bus.wr_addr == bus.rd_addr1)) w_rd1 = bus.wr_data;
        if (c_zero && (bus.rd_addr1 == '0))            w_rd1 = '0;
        w_prd = r_preds[bus.pred_rd_addr];
        if (w_pwr_acc && (bus.pred_wr_addr == bus.pred_rd_addr)) w_prd = bus.pred_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_preds        <= '0;
            r_rd_data0     <= '0;
            r_rd_data1     <= '0;
            r_pred_rd_data <= 1'b0;
        end else begin
            if (w_wr_acc)     r_regs[bus.wr_addr] <= bus.wr_data;
            if (w_rs_reg_we)  r_regs[w_beat_addr] <= bus.ctx_in_data;
            if (w_pwr_acc)    r_preds[bus.pred_wr_addr] <= bus.pred_wr_data;
            if (w_rs_pred_we) r_preds <= bus.ctx_in_data[NUM_PREDS-1:0];
            r_rd_data0     <= w_rd0;
            r_rd_data1     <= w_rd1;
            r_pred_rd_data <= w_prd;
        end
    end

    assign bus.rd_data0      = r_rd_data0;
    assign bus.rd_data1      = r_rd_data1;
    assign bus.pred_rd_data  = r_pred_rd_data;
    assign bus.busy          = w_busy;
    assign bus.ctx_out_valid = w_out_valid;
    // Stream fields are forced to 0 outside SAVE so the bus is quiet when idle.
    assign bus.ctx_out_data  = w_out_valid ? (w_beat_is_pred ? w_sv_pred : w_sv_reg) : '0;
    assign bus.ctx_out_idx   = w_out_valid ? w_beat : '0;

endmodule
`default_nettype wire

// File: tb/tb_gpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_regfile
// Purpose  : Directed self-checking bench for gpu_regfile: read/write with
//            bypass, zero register, predicates, save/restore streams with
//            back-pressure, ignored requests while busy, and mid-restore reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpu_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpu_regfile_if #(.DATA_W(32), .NUM_REGS(16), .NUM_PREDS(4), .CTX_REGS(8)) bus ();

    gpu_regfile #(
        .DATA_W(32), .NUM_REGS(16), .NUM_PREDS(4),
        .CTX_BASE(0), .CTX_REGS(8), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    logic [31:0] exp_beats [9];

    always @(negedge clk) if (bus.done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic write_pred(input int a, input logic d);
        bus.pred_wr_en = 1'b1; bus.pred_wr_addr = 2'(a); bus.pred_wr_data = d;
        tick();
        bus.pred_wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input int a, input logic [31:0] exp);
        bus.rd_addr0 = 4'(a);
        tick();
        check(tag, bus.rd_data0, exp);
    endtask

    task automatic pred_check(input string tag, input int a, input logic exp);
        bus.pred_rd_addr = 2'(a);
        tick();
        check(tag, 32'(bus.pred_rd_data), 32'(exp));
    endtask

    // toggle: ready alternates 0/1 starting stalled. interfere: on the first
    // stalled cycle also drive a port write to r4 and a restore request.
    task automatic run_save(input bit toggle, input bit interfere);
        int b = 0;
        int cyc = 0;
        int d0 = n_done;
        bit acc;
        bus.save_start = 1'b1;
        tick();
        bus.save_start = 1'b0;
        check("save_busy", 32'(bus.busy), 32'd1);
        while (b <= 8 && cyc < 60) begin
            check("save_valid", 32'(bus.ctx_out_valid), 32'd1);
            check("save_idx",   32'(bus.ctx_out_idx), 32'(b));
            check("save_data",  bus.ctx_out_data, exp_beats[b]);
            acc = !toggle || (cyc % 2 == 1);
            bus.ctx_out_ready = acc;
            if (interfere && cyc == 0) begin
                bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 32'h77;
                bus.restore_start = 1'b1;
            end
            tick();
            bus.wr_en = 1'b0;
            bus.restore_start = 1'b0;
            if (acc) b++;
            cyc++;
        end
        bus.ctx_out_ready = 1'b0;
        if (b <= 8) check("save_timeout", 32'(b), 32'd9);
        check("save_done",      32'(bus.done), 32'd1);
        check("save_busy_drop", 32'(bus.busy), 32'd0);
        tick();
        check("save_done_once", 32'(n_done - d0), 32'd1);
        check("save_idle_inrdy", 32'(bus.ctx_in_ready), 32'd0);
    endtask

    task automatic run_restore();
        int b = 0;
        int cyc = 0;
        int d0 = n_done;
        bit v;
        bus.restore_start = 1'b1;
        tick();
        bus.restore_start = 1'b0;
        while (b <= 8 && cyc < 60) begin
            check("rst_ready", 32'(bus.ctx_in_ready), 32'd1);
            v = (cyc % 3 != 1);
            bus.ctx_in_valid = v;
            bus.ctx_in_data  = (b < 8) ? 32'(32'hA0 + b) : 32'h5;
            tick();
            if (v) b++;
            cyc++;
        end
        bus.ctx_in_valid = 1'b0;
        if (b <= 8) check("restore_timeout", 32'(b), 32'd9);
        check("restore_done", 32'(bus.done), 32'd1);
        check("restore_busy", 32'(bus.busy), 32'd0);
        tick();
        check("restore_done_once", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.pred_rd_addr = '0; bus.pred_wr_en = 1'b0; bus.pred_wr_addr = '0; bus.pred_wr_data = 1'b0;
        bus.save_start = 1'b0; bus.restore_start = 1'b0;
        bus.ctx_out_ready = 1'b0; bus.ctx_in_valid = 1'b0; bus.ctx_in_data = '0;
        repeat (2) tick();
        check("reset_busy",  32'(bus.busy), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_valid", 32'(bus.ctx_out_valid), 32'd0);
        check("reset_rd0",   bus.rd_data0, 32'd0);
        rst = 1'b0;
        tick();

        // Write then read on both ports.
        write_reg(3, 32'hDEADBEEF);
        bus.rd_addr0 = 4'd3; bus.rd_addr1 = 4'd3;
        tick();
        check("rd0_r3", bus.rd_data0, 32'hDEADBEEF);
        check("rd1_r3", bus.rd_data1, 32'hDEADBEEF);

        // Same-cycle write/read bypass.
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 32'h12; bus.rd_addr0 = 4'd5;
        tick();
        bus.wr_en = 1'b0;
        check("bypass_r5", bus.rd_data0, 32'h12);
        check("rd1_hold",  bus.rd_data1, 32'hDEADBEEF);

        // Zero register: same-cycle and later read.
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 32'hFFFFFFFF; bus.rd_addr0 = 4'd0;
        tick();
        bus.wr_en = 1'b0;
        check("r0_bypass", bus.rd_data0, 32'd0);
        read_check("r0_stored", 0, 32'd0);

        // Predicates.
        bus.pred_wr_en = 1'b1; bus.pred_wr_addr = 2'd2; bus.pred_wr_data = 1'b1; bus.pred_rd_addr = 2'd2;
        tick();
        bus.pred_wr_en = 1'b0;
        check("p2_bypass", 32'(bus.pred_rd_data), 32'd1);
        pred_check("p0_zero", 0, 1'b0);
        pred_check("p2_set",  2, 1'b1);

        // Load r0..r7 and p = 4'b1010, then save with toggling ready.
        for (int i = 0; i < 8; i++) write_reg(i, 32'(32'h100 + i));
        write_pred(2, 1'b0);
        write_pred(1, 1'b1);
        write_pred(3, 1'b1);
        read_check("load_r7", 7, 32'h107);
        exp_beats[0] = 32'h0;
        for (int i = 1; i < 8; i++) exp_beats[i] = 32'(32'h100 + i);
        exp_beats[8] = 32'hA;
        run_save(1'b1, 1'b0);

        // Restore with gaps in valid.
        run_restore();
        read_check("rs_r0", 0, 32'd0);
        for (int i = 1; i < 8; i++) read_check("rs_reg", i, 32'(32'hA0 + i));
        pred_check("rs_p0", 0, 1'b1);
        pred_check("rs_p1", 1, 1'b0);
        pred_check("rs_p2", 2, 1'b1);
        pred_check("rs_p3", 3, 1'b0);

        // Save with a port write and restore request arriving mid-save.
        exp_beats[0] = 32'h0;
        for (int i = 1; i < 8; i++) exp_beats[i] = 32'(32'hA0 + i);
        exp_beats[8] = 32'h5;
        run_save(1'b1, 1'b1);
        read_check("busy_wr_dropped", 4, 32'hA4);

        // Reset in the middle of a restore, at beat 3.
        bus.rd_addr0 = 4'd4; bus.rd_addr1 = 4'd7; bus.pred_rd_addr = 2'd2;
        bus.restore_start = 1'b1;
        tick();
        bus.restore_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ctx_in_valid = 1'b1;
            bus.ctx_in_data  = 32'(32'hB0 + i);
            tick();
        end
        bus.ctx_in_valid = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_rd0",  bus.rd_data0, 32'hA4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(bus.busy), 32'd0);
        check("arst_ready", 32'(bus.ctx_in_ready), 32'd0);
        check("arst_done",  32'(bus.done), 32'd0);
        check("arst_valid", 32'(bus.ctx_out_valid), 32'd0);
        check("arst_rd0",   bus.rd_data0, 32'd0);
        check("arst_rd1",   bus.rd_data1, 32'd0);
        check("arst_pred",  32'(bus.pred_rd_data), 32'd0);
        check("arst_odata", bus.ctx_out_data, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 1; i < 8; i++) read_check("post_rst_reg", i, 32'd0);
        pred_check("post_rst_p0", 0, 1'b0);
        pred_check("post_rst_p2", 2, 1'b0);
        for (int i = 0; i < 9; i++) exp_beats[i] = 32'd0;
        run_save(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
